// File: rtl/instr_decode_pkg.sv
// Shared types for the mill RV32I decode stage: micro-op and fetched-instruction
// structs, functional-unit enum, RV32I opcodes and immediate extraction helpers.
package instr_decode_pkg;

    typedef enum logic [3:0] {
        FU_ALU    = 4'd0,
        FU_BRANCH = 4'd1,
        FU_JAL    = 4'd2,
        FU_JALR   = 4'd3,
        FU_LOAD   = 4'd4,
        FU_STORE  = 4'd5,
        FU_SYSTEM = 4'd6,
        FU_MUL    = 4'd7,
        FU_DIV    = 4'd8
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_rs1;
        logic        use_rs2;
        logic        wb;
        logic        illegal;
    } uop_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] raw;
    } instr_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // All immediates are sign-extended from raw[31]; B and J keep bit 0 clear.
    function automatic logic [31:0] imm_i(input logic [31:0] raw);
        return {{20{raw[31]}}, raw[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] raw);
        return {{20{raw[31]}}, raw[31:25], raw[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] raw);
        return {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] raw);
        return {raw[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] raw);
        return {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Decoupled valid/ready channels of the decode stage: fetched instructions in,
// decoded micro-ops out. master drives valid/data, slave drives ready.
interface instr_if;
    import instr_decode_pkg::*;

    logic   valid;
    logic   ready;
    instr_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

interface uop_if;
    import instr_decode_pkg::*;

    logic valid;
    logic ready;
    uop_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/instr_decode_skid_buffer.sv
// Generic two-entry decoupled buffer (main M + skid S) with a registered
// upstream ready and a single-cycle flush that empties both entries.
module skid_buffer #(
    parameter type Data = logic [0:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  Data  in_data,
    output logic out_valid,
    input  logic out_ready,
    output Data  out_data
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state, state_nx;
    Data    m_data, m_nx;
    Data    s_data, s_nx;
    logic   ready_q;
    logic   in_fire, out_fire;

    // ready_q mirrors !S.valid for the next cycle; flush opens the input so fetch drains.
    assign in_ready  = ready_q || flush;
    assign out_valid = (state != EMPTY);
    assign out_data  = m_data;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        state_nx = state;
        m_nx     = m_data;
        s_nx     = s_data;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nx = ONE;
                    m_nx     = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_nx = in_data;
                end else if (in_fire) begin
                    state_nx = FULL;
                    s_nx     = in_data;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_nx = ONE;
                    m_nx     = s_data;
                end
            end
            default: state_nx = EMPTY;
        endcase
        // A delivery in the flush cycle has already happened; everything else is dropped.
        if (flush) state_nx = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: payload registers are reset too, so decoded.data reads zero out of reset.
        if (rst) begin
            state   <= EMPTY;
            m_data  <= '0;
            s_data  <= '0;
            ready_q <= 1'b1;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
            state   <= state_nx;
            m_data  <= m_nx;
            s_data  <= s_nx;
            ready_q <= (state_nx != FULL);
        end
    end

endmodule

// File: rtl/instr_decode.sv
// RV32I decode stage: combinational decode in front of a skid buffer holding uops.
// Define MILL_DECODE_RV32M_EN to decode the RV32M multiply/divide encodings.
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter int ILLEGAL_PASSTHRU = 1
) (
    input  logic     clk,
    input  logic     rst,
    instr_if.slave   fetched,
    uop_if.master    decoded,
    input  logic     flush
);

    function automatic uop_t decode(input instr_t in);
        uop_t        u;
        logic [31:0] raw;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        bad;

        raw = in.raw;
        f3  = raw[14:12];
        f7  = raw[31:25];

        u     = '0;
        u.pc  = in.pc;
        u.fu  = FU_ALU;
        u.op  = {1'b0, f3};
        u.rs1 = raw[19:15];
        u.rs2 = raw[24:20];
        u.rd  = raw[11:7];
        bad   = (raw[1:0] != 2'b11);

        case (raw[6:0])
            OP_LUI: begin
                u.op  = 4'h0;
                u.rs1 = 5'd0;
                u.imm = imm_u(raw);
                u.wb  = 1'b1;
            end
            OP_AUIPC: begin
                u.op  = 4'hF;
                u.imm = imm_u(raw);
                u.wb  = 1'b1;
            end
            OP_JAL: begin
                u.fu  = FU_JAL;
                u.op  = 4'h0;
                u.imm = imm_j(raw);
                u.wb  = 1'b1;
            end
            OP_JALR: begin
                u.fu      = FU_JALR;
                u.imm     = imm_i(raw);
                u.use_rs1 = 1'b1;
                u.wb      = 1'b1;
                bad       = bad || (f3 != 3'd0);
            end
            OP_BRANCH: begin
                u.fu      = FU_BRANCH;
                u.imm     = imm_b(raw);
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
                bad       = bad || (f3 == 3'd2) || (f3 == 3'd3);
            end
            OP_LOAD: begin
                u.fu      = FU_LOAD;
                u.imm     = imm_i(raw);
                u.use_rs1 = 1'b1;
                u.wb      = 1'b1;
                bad       = bad || (f3 == 3'd3) || (f3 >= 3'd6);
            end
            OP_STORE: begin
                u.fu      = FU_STORE;
                u.imm     = imm_s(raw);
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
                bad       = bad || (f3 > 3'd2);
            end
            OP_IMM: begin
                u.imm     = imm_i(raw);
                u.use_rs1 = 1'b1;
                u.wb      = 1'b1;
                // Shift immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
                if (f3 == 3'd1) begin
                    bad = bad || (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    bad  = bad || ((f7 != 7'h00) && (f7 != 7'h20));
                    u.op = {f7[5], f3};
                end
            end
            OP_REG: begin
                u.use_rs1 = 1'b1;
                u.use_rs2 = 1'b1;
                u.wb      = 1'b1;
                case (f7)
                    7'h00: ;
                    7'h20: begin
                        u.op = {1'b1, f3};
                        bad  = bad || ((f3 != 3'd0) && (f3 != 3'd5));
                    end
`ifdef MILL_DECODE_RV32M_EN
                    7'h01: u.fu = f3[2] ? FU_DIV : FU_MUL;
`else
                    7'h01: bad = 1'b1;
`endif
                    default: bad = 1'b1;
                endcase
            end
            OP_FENCE: begin
                u.op = 4'h0;
                bad  = bad || (f3 != 3'd0);
            end
            OP_SYSTEM: begin
                // CSR forms with f3[2]=0 read rs1; all CSR forms write rd, ECALL/EBREAK do not.
                u.fu      = FU_SYSTEM;
                u.imm     = imm_i(raw);
                u.use_rs1 = (f3[1:0] != 2'b00) && !f3[2];
                u.wb      = (f3 != 3'd0);
                bad       = bad || (f3 == 3'd4);
            end
            default: bad = 1'b1;
        endcase

        if (bad) begin
            u         = '0;
            u.pc      = in.pc;
            u.illegal = 1'b1;
        end else begin
            u.wb = u.wb && (u.rd != 5'd0);
        end
        return u;
    endfunction

    uop_t dec_uop;
    logic sb_in_valid;

    assign dec_uop     = decode(fetched.data);
    // With passthrough disabled an illegal word is still consumed from fetch, just never stored.
    assign sb_in_valid = fetched.valid && (!dec_uop.illegal || (ILLEGAL_PASSTHRU != 0));

    skid_buffer #(.Data(uop_t)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (sb_in_valid),
        .in_ready  (fetched.ready),
        .in_data   (dec_uop),
        .out_valid (decoded.valid),
        .out_ready (decoded.ready),
        .out_data  (decoded.data)
    );

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: a reference decoder built from the ISA
// rules feeds a scoreboard queue that a negedge monitor drains and compares.
module tb_instr_decode;
    import instr_decode_pkg::*;

    localparam int PASSTHRU = 1;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;

    instr_if fetched_bus ();
    uop_if   decoded_bus ();

    instr_decode #(.ILLEGAL_PASSTHRU(PASSTHRU)) dut (
        .clk     (clk),
        .rst     (rst),
        .fetched (fetched_bus),
        .decoded (decoded_bus),
        .flush   (flush)
    );

    always #5 clk = ~clk;

    uop_t        exp_q[$];
    int          n_cmp  = 0;
    int          n_bad  = 0;
    bit          mon_en = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: legality table per opcode, immediates via arithmetic shifts.
    function automatic uop_t ref_decode(input logic [31:0] pc, input logic [31:0] raw);
        uop_t               u;
        logic [6:0]         opc;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic signed [31:0] sx;
        logic [31:0]        t, i_imm, s_imm, b_imm, u_imm, j_imm;
        bit                 ok, r1, r2, w;
        fu_t                fu;
        logic [3:0]         op;
        logic [31:0]        imm;

        opc = raw[6:0];
        f3  = raw[14:12];
        f7  = raw[31:25];
        sx  = raw;
        i_imm = sx >>> 20;
        t     = sx >>> 25;
        s_imm = (t << 5) | 32'(raw[11:7]);
        t     = sx >>> 31;
        b_imm = (t << 12) | (32'(raw[7]) << 11) | (32'(raw[30:25]) << 5) | (32'(raw[11:8]) << 1);
        j_imm = (t << 20) | (32'(raw[19:12]) << 12) | (32'(raw[20]) << 11) | (32'(raw[30:21]) << 1);
        u_imm = raw & 32'hFFFF_F000;

        ok = 1; r1 = 0; r2 = 0; w = 0; fu = FU_ALU; op = {1'b0, f3}; imm = 0;
        u = '0;
        u.rs1 = raw[19:15];
        u.rs2 = raw[24:20];
        u.rd  = raw[11:7];
        case (opc)
            OP_LUI:    begin imm = u_imm; w = 1; op = 0; u.rs1 = 0; end
            OP_AUIPC:  begin imm = u_imm; w = 1; op = 4'hF; end
            OP_JAL:    begin fu = FU_JAL; imm = j_imm; w = 1; op = 0; end
            OP_JALR:   begin fu = FU_JALR; imm = i_imm; r1 = 1; w = 1; ok = (f3 == 0); end
            OP_BRANCH: begin fu = FU_BRANCH; imm = b_imm; r1 = 1; r2 = 1; ok = (f3 inside {0, 1, 4, 5, 6, 7}); end
            OP_LOAD:   begin fu = FU_LOAD; imm = i_imm; r1 = 1; w = 1; ok = (f3 inside {0, 1, 2, 4, 5}); end
            OP_STORE:  begin fu = FU_STORE; imm = s_imm; r1 = 1; r2 = 1; ok = (f3 < 3); end
            OP_IMM: begin
                imm = i_imm; r1 = 1; w = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) begin ok = (f7 == 0 || f7 == 32); op = (f7 == 32) ? 4'hD : 4'h5; end
            end
            OP_REG: begin
                r1 = 1; r2 = 1; w = 1;
                if (f7 == 32) begin ok = (f3 == 0 || f3 == 5); op = 4'h8 + 4'(f3); end
                else if (f7 == 1) begin
`ifdef MILL_DECODE_RV32M_EN
                    fu = (f3 >= 4) ? FU_DIV : FU_MUL;
`else
                    ok = 0;
`endif
                end else ok = (f7 == 0);
            end
            OP_FENCE:  begin op = 0; ok = (f3 == 0); end
            OP_SYSTEM: begin fu = FU_SYSTEM; imm = i_imm; r1 = (f3 inside {1, 2, 3}); w = (f3 != 0); ok = (f3 != 4); end
            default:   ok = 0;
        endcase

        if (!ok) begin
            u = '0;
            u.illegal = 1;
        end else begin
            u.fu = fu; u.op = op; u.imm = imm;
            u.use_rs1 = r1; u.use_rs2 = r2;
            u.wb = w && (u.rd != 0);
        end
        u.pc = pc;
        return u;
    endfunction

    function automatic logic [31:0] rand_raw();
        logic [31:0] r;
        logic [6:0]  opcs[11] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
                                   OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM};
        logic [6:0]  f7s[3] = '{7'h00, 7'h20, 7'h01};
        r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 10)];
        if ((r[6:0] == OP_REG || r[6:0] == OP_IMM) && $urandom_range(0, 3) != 0)
            r[31:25] = f7s[$urandom_range(0, 2)];
        return r;
    endfunction

    // Scoreboard monitor: mid-cycle, pop on decoded fire, push on fetched fire.
    always @(negedge clk) begin
        uop_t u;
        if (rst || !mon_en) begin
            exp_q.delete();
        end else begin
            check("out_valid", 128'(decoded_bus.valid), 128'(exp_q.size() > 0));
            check("in_ready", 128'(fetched_bus.ready), 128'(flush || exp_q.size() < 2));
            if (decoded_bus.valid && exp_q.size() > 0) begin
                check("uop", 128'(decoded_bus.data), 128'(exp_q[0]));
                if (decoded_bus.ready) void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            else if (fetched_bus.valid && fetched_bus.ready) begin
                u = ref_decode(fetched_bus.data.pc, fetched_bus.data.raw);
                if (!u.illegal || PASSTHRU != 0) exp_q.push_back(u);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] raw);
        bit done = 0;
        int n = 0;
        fetched_bus.valid = 1'b1;
        fetched_bus.data  = {pc, raw};
        while (!done && n < 50) begin
            @(negedge clk);
            done = fetched_bus.ready;
            step();
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: raw %08h not accepted in 50 cycles", raw);
        end
    endtask

    // Stream new words with the consumer stalled; returns how many were accepted.
    task automatic stall_fill(input int cycles, output int acc);
        bit took = 1;
        acc = 0;
        decoded_bus.ready = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (took) begin
                pc_ctr += 4;
                fetched_bus.data = {pc_ctr, rand_raw()};
            end
            fetched_bus.valid = 1'b1;
            @(negedge clk);
            took = fetched_bus.ready;
            if (took) acc++;
            step();
        end
    endtask

    task automatic drain();
        fetched_bus.valid = 1'b0;
        decoded_bus.ready = 1'b1;
        flush = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        bit  took;
        fetched_bus.valid = 1'b0;
        fetched_bus.data  = '0;
        decoded_bus.ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid", 128'(decoded_bus.valid), 128'(0));
        check("rst_data", 128'(decoded_bus.data), 128'(0));
        check("rst_ready", 128'(fetched_bus.ready), 128'(1));
        @(posedge clk); #3 rst = 1'b0;
        mon_en = 1'b1;
        step();

        // addi x1,x0,5 held by a stalled consumer
        send(32'h0, 32'h0050_0093);
        fetched_bus.valid = 1'b0;
        @(negedge clk);
        check("addi_valid", 128'(decoded_bus.valid), 128'(1));
        check("addi_fu", 128'(decoded_bus.data.fu), 128'(FU_ALU));
        check("addi_rd", 128'(decoded_bus.data.rd), 128'(1));
        check("addi_rs1", 128'(decoded_bus.data.rs1), 128'(0));
        check("addi_imm", 128'(decoded_bus.data.imm), 128'(5));
        check("addi_wb", 128'(decoded_bus.data.wb), 128'(1));
        check("addi_use_rs2", 128'(decoded_bus.data.use_rs2), 128'(0));
        decoded_bus.ready = 1'b1;
        step();

        // lw then sw back to back
        send(32'h4, 32'h0080_A103);
        fetched_bus.data = {32'h8, 32'hFE20_AE23};
        @(negedge clk);
        check("lw_imm", 128'(decoded_bus.data.imm), 128'(8));
        check("lw_rd", 128'(decoded_bus.data.rd), 128'(2));
        check("lw_fu", 128'(decoded_bus.data.fu), 128'(FU_LOAD));
        step();
        fetched_bus.valid = 1'b0;
        @(negedge clk);
        check("sw_imm", 128'(decoded_bus.data.imm), 128'(32'hFFFF_FFFC));
        check("sw_rs2", 128'(decoded_bus.data.rs2), 128'(2));
        check("sw_wb", 128'(decoded_bus.data.wb), 128'(0));
        drain();

        // mul x3,x1,x2
        send(32'h20, 32'h0220_81B3);
        fetched_bus.valid = 1'b0;
        @(negedge clk);
`ifdef MILL_DECODE_RV32M_EN
        check("mul_fu", 128'(decoded_bus.data.fu), 128'(FU_MUL));
        check("mul_rd", 128'(decoded_bus.data.rd), 128'(3));
`else
        check("mul_illegal", 128'(decoded_bus.data.illegal), 128'(1));
        check("mul_wb", 128'(decoded_bus.data.wb), 128'(0));
`endif
        step();

        // All-ones word
        send(32'h24, 32'hFFFF_FFFF);
        fetched_bus.valid = 1'b0;
        @(negedge clk);
        check("ones_illegal", 128'(decoded_bus.data.illegal), 128'(1));
        check("ones_regs", 128'({decoded_bus.data.rs1, decoded_bus.data.rs2, decoded_bus.data.rd}), 128'(0));
        drain();

        // Stall: exactly two absorbed, ready low once FULL, drains in order on release
        stall_fill(4, acc);
        check("stall_accepted", 128'(acc), 128'(2));
        @(negedge clk);
        check("stall_ready_low", 128'(fetched_bus.ready), 128'(0));
        drain();

        // Flush while FULL with an input firing
        stall_fill(3, acc);
        pc_ctr += 4;
        fetched_bus.data  = {pc_ctr, 32'h0050_0093};
        fetched_bus.valid = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        fetched_bus.valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 128'(decoded_bus.valid), 128'(0));
        check("flush_ready", 128'(fetched_bus.ready), 128'(1));
        drain();

        // Asynchronous reset mid-stall
        stall_fill(3, acc);
        fetched_bus.valid = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("arst_valid", 128'(decoded_bus.valid), 128'(0));
        @(posedge clk); #3 rst = 1'b0;
        decoded_bus.ready = 1'b1;
        @(negedge clk);
        check("arst_ready", 128'(fetched_bus.ready), 128'(1));
        step();

        // Randomized traffic with stalls and occasional flushes
        took = 1;
        for (int c = 0; c < 400; c++) begin
            if (!fetched_bus.valid || took) begin
                pc_ctr += 4;
                fetched_bus.data = {pc_ctr, rand_raw()};
            end
            fetched_bus.valid = ($urandom_range(0, 9) < 8);
            decoded_bus.ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            took = fetched_bus.valid && fetched_bus.ready;
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
